// File: rtl/carry_lookahead_adder.sv
// Two-level carry-lookahead adder with one registered output stage.
// Four-bit groups form their own carries; a second-level unit supplies every group carry-in.

module cla_group4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic [3:0] carry,
   output logic       grp_gen,
   output logic       grp_prop
);

   logic [3:0] g;
   logic [3:0] p;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is a flat sum of products; no carry feeds another carry.
   assign carry[0] = cin;
   assign carry[1] = g[0] | (p[0] & cin);
   assign carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cin);

   // The group carry-out (c4 = G | P & cin) is formed by the second-level unit.
   assign grp_gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
   assign grp_prop = &p;

   assign sum = p ^ carry;

endmodule

module cla_lookahead #(
   parameter int N = 4
) (
   input  logic [N-1:0] grp_gen,
   input  logic [N-1:0] grp_prop,
   input  logic         cin,
   output logic [N:0]   carry
);

   logic acc;
   logic term;

   // carry[i] = OR over j<i of (G[j] & P[j+1..i-1]) OR (cin & P[0..i-1]),
   // expanded in full so group carries never ripple through one another.
   always_comb begin
      carry = '0;
      acc   = 1'b0;
      term  = 1'b0;
      carry[0] = cin;
      for (int i = 1; i <= N; i++) begin
         acc = 1'b0;
         for (int j = 0; j < i; j++) begin
            term = grp_gen[j];
            for (int k = j + 1; k < i; k++) begin
               term = term & grp_prop[k];
            end
            acc = acc | term;
         end
         term = cin;
         for (int k = 0; k < i; k++) begin
            term = term & grp_prop[k];
         end
         carry[i] = acc | term;
      end
   end

endmodule

module carry_lookahead_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NGRP = WIDTH / 4;

   logic [NGRP-1:0]  grp_gen;
   logic [NGRP-1:0]  grp_prop;
   logic [NGRP:0]    grp_carry;
   logic [WIDTH-1:0] bit_carry;
   logic [WIDTH-1:0] sum_comb;

   for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      cla_group4 u_grp (
         .a        (a[gi*4 +: 4]),
         .b        (b[gi*4 +: 4]),
         .cin      (grp_carry[gi]),
         .sum      (sum_comb[gi*4 +: 4]),
         .carry    (bit_carry[gi*4 +: 4]),
         .grp_gen  (grp_gen[gi]),
         .grp_prop (grp_prop[gi])
      );
   end

   cla_lookahead #(.N(NGRP)) u_lookahead (
      .grp_gen  (grp_gen),
      .grp_prop (grp_prop),
      .cin      (cin),
      .carry    (grp_carry)
   );

   // Overflow compares the carry into the MSB with the carry out of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         sum  <= sum_comb;
         cout <= grp_carry[NGRP];
         ovf  <= bit_carry[WIDTH-1] ^ grp_carry[NGRP];
      end
   end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Scoreboard bench for carry_lookahead_adder: driver pushes expected results,
// a monitor pops and compares one cycle after each applied operand set.

module tb_carry_lookahead_adder;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } expect_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        rst;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vector_t;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   expect_t exp_q[$];
   int      checks;
   int      fails;

   carry_lookahead_adder #(.WIDTH(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed directed vectors, applied on consecutive cycles.
   vector_t vecs [11] = '{
      '{16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0},
      '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0},
      '{16'hFFFA, 16'h0001, 1'b0, 1'b0, 16'hFFFB, 1'b0, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0},
      '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0},
      '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0},
      '{16'h5555, 16'hAAAA, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}
   };

   task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                input logic vcin, input logic vrst,
                                input logic [15:0] esum, input logic ecout,
                                input logic eovf);
      expect_t e;
      @(negedge clk);
      a   = va;
      b   = vb;
      cin = vcin;
      rst = vrst;
      e.sum  = esum;
      e.cout = ecout;
      e.ovf  = eovf;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] required);
      checks++;
      if (actual !== required) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, required, $time);
      end
   endtask

   // Monitor: the DUT presents a result every cycle, one edge after its inputs.
   always @(posedge clk) begin
      expect_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("sum",  sum,           e.sum);
         checkOutput("cout", {15'd0, cout}, {15'd0, e.cout});
         checkOutput("ovf",  {15'd0, ovf},  {15'd0, e.ovf});
      end
   end

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic        rr;
      logic [16:0] full;
      logic        sovf;
      checks = 0;
      fails  = 0;
      rst = 1'b1;
      a   = '0;
      b   = '0;
      cin = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].rst,
                       vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      end

      for (int n = 0; n < 10000; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         rr = ($urandom_range(0, 49) == 0);
         full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         sovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
         if (rr)
            applyStimulus(ra, rb, rc, 1'b1, 16'h0000, 1'b0, 1'b0);
         else
            applyStimulus(ra, rb, rc, 1'b0, full[15:0], full[16], sovf);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
